// File: rtl/stopwatch_ctrl.sv
// Stopwatch control block: synchronises and edge-detects the three key
// levels, runs the IDLE/RUN/PAUSE/LAP state machine, and produces the
// registered run/tick/clear/freeze/display-select controls.
//
// Key-event handshake: each key is a raw level. An event is a single-cycle
// strobe taken from the rising edge after synchronisation. It needs no
// acknowledge, and a held key yields one event only. A key first sampled
// high at edge k changes state and the outputs at edge k+2.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       key_start,
  input  logic       key_lap,
  input  logic       key_mode,
  output logic       run,
  output logic       tick,
  output logic       clear,
  output logic       freeze,
  output logic       disp_sel,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam logic [23:0] PRESC_TERM = 24'(TICK_DIV - 1);

  // Key vector order: {mode, lap, start}.
  logic [2:0]  key_s1, key_s2, key_s3;
  logic [2:0]  key_ev;
  logic        start_ev, lap_ev, mode_ev;

  state_t      state_q, state_nx;
  logic        run_d, freeze_d, clear_d;
  logic [23:0] presc_q;

  // Two-flop synchroniser plus edge register. Everything resets high so a
  // key held through reset release cannot look like a fresh press.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= '1;
      key_s2 <= '1;
      key_s3 <= '1;
    end else begin
      key_s1 <= {key_mode, key_lap, key_start};
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign key_ev   = key_s2 & ~key_s3;
  assign start_ev = key_ev[0];
  assign lap_ev   = key_ev[1];
  assign mode_ev  = key_ev[2];

  // State register and the registered control outputs.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      run     <= 1'b0;
      freeze  <= 1'b0;
      clear   <= 1'b0;
    end else begin
      state_q <= state_nx;
      run     <= run_d;
      freeze  <= freeze_d;
      clear   <= clear_d;
    end
  end

  // Next-state decode; when start and lap arrive together, start wins.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ev) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (start_ev)    state_nx = ST_PAUSE;
        else if (lap_ev) state_nx = ST_LAP;
      end
      ST_LAP: begin
        if (start_ev)    state_nx = ST_PAUSE;
        else if (lap_ev) state_nx = ST_RUN;
      end
      ST_PAUSE: begin
        if (start_ev)    state_nx = ST_RUN;
        else if (lap_ev) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output decode: run/freeze follow the next state; clear pulses on a lap
  // event taken in IDLE or PAUSE, both of which cannot be ticking.
  always_comb begin
    run_d    = (state_nx == ST_RUN) || (state_nx == ST_LAP);
    freeze_d = (state_nx == ST_LAP);
    clear_d  = lap_ev && !start_ev &&
               ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
  end

  // Prescaler: advances while run is high (including the edge that enters
  // PAUSE, so a terminal count there still ticks), holds in PAUSE and is
  // zeroed on the way into IDLE.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= run && (presc_q == PRESC_TERM);
      if (run) begin
        if (presc_q == PRESC_TERM) presc_q <= '0;
        else                       presc_q <= presc_q + 24'd1;
      end else if (state_nx == ST_IDLE) begin
        presc_q <= '0;
      end
    end
  end

  // Display source toggles on every mode event, in any state.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) disp_sel <= 1'b0;
    else if (mode_ev) disp_sel <= ~disp_sel;
  end

  assign state = state_q;

endmodule
